// File: rtl/bus_sram_responder_if.sv
// Simple memory bus between the core (master) and the SRAM responder (slave).
// Handshake: a request is taken on any rising edge where busy=0 and rd_en or wr_en is high;
// rd_vld is a one-cycle pulse qualifying rd_data, which then holds until the next read completes.
interface bus_sram_responder_if;
    logic        ahb_rd_en;
    logic        ahb_wr_en;
    logic [31:0] ahb_addr;
    logic [31:0] ahb_wr_data;
    logic [1:0]  ahb_data_size;
    logic [31:0] ahb_rd_data;
    logic        ahb_rd_vld;
    logic        ahb_busy;

    modport master (
        output ahb_rd_en, ahb_wr_en, ahb_addr, ahb_wr_data, ahb_data_size,
        input  ahb_rd_data, ahb_rd_vld, ahb_busy
    );

    modport slave (
        input  ahb_rd_en, ahb_wr_en, ahb_addr, ahb_wr_data, ahb_data_size,
        output ahb_rd_data, ahb_rd_vld, ahb_busy
    );
endinterface

// File: rtl/bus_sram_responder.sv
// Single-port 32-bit SRAM responder with programmable wait states and byte/half/word lanes.
// One access at a time: IDLE latches the request, WAIT burns cycles, DONE commits or reads.
module bus_sram_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bus_sram_responder_if.slave   bus,
    output logic [1:0]            state_dbg
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [1:0]            state;
    logic [3:0]            wait_cnt;
    logic                  req_is_wr;
    logic [ADDR_WIDTH+1:0] req_addr;
    logic [31:0]           req_data;
    logic [1:0]            req_size;
    logic [31:0]           mem [2**ADDR_WIDTH];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           mem_word;
    logic [31:0]           rd_value;
    logic [31:0]           wr_value;
    logic [3:0]            lane_en;
    logic                  unused_addr_bits;

    // Upper address bits are deliberately dropped so the space wraps.
    assign unused_addr_bits = ^bus.ahb_addr[31:ADDR_WIDTH+2];
    assign word_idx  = req_addr[ADDR_WIDTH+1:2];
    assign mem_word  = mem[word_idx];
    assign bus.ahb_busy = (state != ST_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            req_is_wr <= 1'b0;
            req_addr  <= '0;
            req_data  <= 32'h0;
            req_size  <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.ahb_wr_en || bus.ahb_rd_en) begin
                        req_is_wr <= bus.ahb_wr_en;
                        req_addr  <= bus.ahb_addr[ADDR_WIDTH+1:0];
                        req_data  <= bus.ahb_wr_data;
                        req_size  <= bus.ahb_data_size;
                        wait_cnt  <= CNT_LOAD;
                        state     <= (WAIT_STATES > 0) ? ST_WAIT : ST_DONE;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Lane selection and write-data replication; size 11 behaves as a word.
    always_comb begin
        lane_en  = 4'b1111;
        wr_value = req_data;
        case (req_size)
            2'b00: begin
                lane_en  = 4'b0001 << req_addr[1:0];
                wr_value = {4{req_data[7:0]}};
            end
            2'b01: begin
                lane_en  = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_value = {2{req_data[15:0]}};
            end
            default: begin
                lane_en  = 4'b1111;
                wr_value = req_data;
            end
        endcase
    end

    always_comb begin
        rd_value = mem_word;
        case (req_size)
            2'b00: begin
                case (req_addr[1:0])
                    2'd0:    rd_value = {24'h0, mem_word[7:0]};
                    2'd1:    rd_value = {24'h0, mem_word[15:8]};
                    2'd2:    rd_value = {24'h0, mem_word[23:16]};
                    default: rd_value = {24'h0, mem_word[31:24]};
                endcase
            end
            2'b01:   rd_value = req_addr[1] ? {16'h0, mem_word[31:16]} : {16'h0, mem_word[15:0]};
            default: rd_value = mem_word;
        endcase
    end

    // Memory is not reset; a reset before DONE leaves state IDLE so nothing commits.
    always_ff @(posedge clk) begin
        if (state == ST_DONE && req_is_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_en[k]) begin
                    mem[word_idx][8*k +: 8] <= wr_value[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ahb_rd_vld  <= 1'b0;
            bus.ahb_rd_data <= 32'h0;
        end else begin
            bus.ahb_rd_vld <= (state == ST_DONE) && !req_is_wr;
            if (state == ST_DONE && !req_is_wr) begin
                bus.ahb_rd_data <= rd_value;
            end
        end
    end
endmodule

// File: tb/tb_bus_sram_responder.sv
// Directed bench for bus_sram_responder (ADDR_WIDTH=10, WAIT_STATES=2).
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_bus_sram_responder;
    localparam int WS = 2;

    logic clk;
    logic rst_n;
    logic [1:0] state_dbg;
    int checks;
    int failures;

    bus_sram_responder_if bus ();

    bus_sram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One access from request to the cycle after DONE; poke drives a stray write while busy.
    task automatic access(input string tag, input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] sz, input logic [31:0] exp_rd,
                          input logic poke);
        bus.ahb_wr_en     = wr;
        bus.ahb_rd_en     = rd;
        bus.ahb_addr      = a;
        bus.ahb_wr_data   = d;
        bus.ahb_data_size = sz;
        @(posedge clk); #1;
        bus.ahb_wr_en = 1'b0;
        bus.ahb_rd_en = 1'b0;
        check({tag, "/busy0"}, 32'(bus.ahb_busy), 32'd1);
        for (int i = 1; i <= WS; i++) begin
            if (poke && i == 1) begin
                bus.ahb_wr_en   = 1'b1;
                bus.ahb_rd_en   = 1'b1;
                bus.ahb_addr    = 32'h4;
                bus.ahb_wr_data = 32'hAA;
                bus.ahb_data_size = 2'b10;
            end
            @(posedge clk); #1;
            bus.ahb_wr_en = 1'b0;
            bus.ahb_rd_en = 1'b0;
            check({tag, "/busy"}, 32'(bus.ahb_busy), 32'd1);
            check({tag, "/vld_early"}, 32'(bus.ahb_rd_vld), 32'd0);
        end
        @(posedge clk); #1;
        check({tag, "/busy_end"}, 32'(bus.ahb_busy), 32'd0);
        check({tag, "/vld"}, 32'(bus.ahb_rd_vld), 32'(rd && !wr));
        if (rd && !wr) check({tag, "/data"}, bus.ahb_rd_data, exp_rd);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.ahb_rd_en = 1'b1;
        bus.ahb_wr_en = 1'b0;
        bus.ahb_addr = 32'h0;
        bus.ahb_wr_data = 32'h0;
        bus.ahb_data_size = 2'b10;

        // Reset held with a read strobe present.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst/busy", 32'(bus.ahb_busy), 32'd0);
            check("rst/vld", 32'(bus.ahb_rd_vld), 32'd0);
            check("rst/data", bus.ahb_rd_data, 32'h0);
            check("rst/state", 32'(state_dbg), 32'd0);
        end
        rst_n = 1'b1;
        bus.ahb_rd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst/vld", 32'(bus.ahb_rd_vld), 32'd0);
            check("post_rst/busy", 32'(bus.ahb_busy), 32'd0);
        end

        // Word write/read.
        access("w_word", 1, 0, 32'h10, 32'hDEADBEEF, 2'b10, 32'h0, 0);
        access("r_word", 0, 1, 32'h10, 32'h0, 2'b10, 32'hDEADBEEF, 0);
        access("r_size3", 0, 1, 32'h13, 32'h0, 2'b11, 32'hDEADBEEF, 0);

        // Byte and halfword lanes.
        access("w_zero20", 1, 0, 32'h20, 32'h0, 2'b10, 32'h0, 0);
        access("w_byte22", 1, 0, 32'h22, 32'hFFFFFFA5, 2'b00, 32'h0, 0);
        access("w_half20", 1, 0, 32'h21, 32'hFFFF1234, 2'b01, 32'h0, 0);
        access("r_word20", 0, 1, 32'h20, 32'h0, 2'b10, 32'h00A51234, 0);
        access("r_byte22", 0, 1, 32'h22, 32'h0, 2'b00, 32'h000000A5, 0);
        access("r_byte21", 0, 1, 32'h21, 32'h0, 2'b00, 32'h00000012, 0);
        access("r_half22", 0, 1, 32'h23, 32'h0, 2'b01, 32'h000000A5, 0);

        // Collision: write wins, read dropped; rd_data holds its last value.
        access("collide", 1, 1, 32'h4, 32'h55, 2'b10, 32'h0, 0);
        check("rd_data_hold", bus.ahb_rd_data, 32'h000000A5);

        // Requests while busy are ignored.
        access("r_poke4", 0, 1, 32'h4, 32'h0, 2'b10, 32'h00000055, 1);
        access("r_after_poke", 0, 1, 32'h4, 32'h0, 2'b10, 32'h00000055, 0);

        // Address wrap.
        access("w_wrap", 1, 0, 32'h1000, 32'h11, 2'b10, 32'h0, 0);
        access("r_wrap", 0, 1, 32'h0, 32'h0, 2'b10, 32'h00000011, 0);

        // Reset in the WAIT cycle aborts the write.
        access("w_zero30", 1, 0, 32'h30, 32'h0, 2'b10, 32'h0, 0);
        bus.ahb_wr_en = 1'b1;
        bus.ahb_addr = 32'h30;
        bus.ahb_wr_data = 32'hFFFFFFFF;
        bus.ahb_data_size = 2'b10;
        @(posedge clk); #1;
        bus.ahb_wr_en = 1'b0;
        check("midrst/state_wait", 32'(state_dbg), 32'd1);
        rst_n = 1'b0;
        #2;
        check("midrst/busy", 32'(bus.ahb_busy), 32'd0);
        check("midrst/state", 32'(state_dbg), 32'd0);
        check("midrst/vld", 32'(bus.ahb_rd_vld), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("midrst/idle", 32'(bus.ahb_busy), 32'd0);
        end
        access("r_after_midrst", 0, 1, 32'h30, 32'h0, 2'b10, 32'h00000000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_sram_responder.md
# bus_sram_responder

Single-port on-chip SRAM that acts as the responder end of the core's simple memory bus (rd_en/wr_en/addr/wr_data/data_size in; rd_data/rd_vld/busy out). It sits on the data-side bus opposite the processor core. It accepts one byte, halfword or word access at a time, inserts a programmable number of wait states, then completes the write or returns read data with a one-cycle valid pulse.

## Interface
- ADDR_WIDTH, 10, word-address bits; memory depth is 2^ADDR_WIDTH 32-bit words (default 4 KB).
- WAIT_STATES, 2, extra busy cycles inserted before completion; legal range 0..15.
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ahb_rd_en  input  1  read request strobe, sampled only while busy=0.
- ahb_wr_en  input  1  write request strobe, sampled only while busy=0.
- ahb_addr  input  32  byte address.
- ahb_wr_data  input  32  write data, right-justified (byte in [7:0], half in [15:0]).
- ahb_data_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- ahb_rd_data  output  32  read data, right-justified, zero-extended.
- ahb_rd_vld  output  1  one-cycle pulse marking ahb_rd_data valid.
- ahb_busy  output  1  high while an access is in progress; requests are ignored while high.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE (busy=0): on a rising edge with ahb_wr_en=1 or ahb_rd_en=1, latch addr, wr_data, size and kind.
  - If both strobes are set, the access is a write; the read is dropped.
  - Next state is WAIT if WAIT_STATES>0, else DONE. The wait counter loads WAIT_STATES-1.
- WAIT (busy=1): decrement the counter each cycle. Go to DONE when the counter is 0.
- DONE (busy=1): perform the access, then return to IDLE.
- Address decode: word index = addr[ADDR_WIDTH+1:2]. Upper bits are ignored, so the address space wraps modulo 2^(ADDR_WIDTH+2) bytes.
- Alignment: halfword uses addr[1] and ignores addr[0]; word ignores addr[1:0]. There is no fault.
- Little-endian lanes: byte lane k is bits [8k+7:8k].
- Write: the byte is replicated to lane addr[1:0]; the halfword goes to lanes {addr[1],0} and {addr[1],1}; a word writes all lanes. Only selected lanes change, and the commit happens on the DONE edge.
- Read: the selected lanes are shifted down to bit 0 and the upper bits are zeroed. Sign extension is the core's job.
- Requests arriving in WAIT or DONE are ignored. There is no queueing.

## Timing
- Reset values: ahb_busy=0, ahb_rd_vld=0, ahb_rd_data=32'h0, state IDLE, counter 0. Memory contents are not reset.
- Request sampled at edge E0 (busy=0 in that cycle).
- busy is 1 from E0 until edge E0+WAIT_STATES+1, which is the DONE→IDLE edge.
- Read: rd_vld=1 and rd_data valid for exactly one cycle, registered out of DONE, i.e. in the cycle after E0+WAIT_STATES+1.
  - busy is already 0 in that cycle, so a new request may be presented in the rd_vld cycle.
  - rd_data holds its value until the next read completes.
- Read latency from request cycle to rd_vld cycle is WAIT_STATES+2. With WAIT_STATES=0 it is 2 cycles.
- Write is visible to a read accepted on or after edge E0+WAIT_STATES+1.
- Reset asserted mid-access: return to IDLE immediately, busy=0, rd_vld=0. A write not yet at its DONE edge is not committed; a pending read produces no rd_vld.
- Throughput: one access per WAIT_STATES+2 cycles.

## Test plan
- Reset: hold rst_n=0 with rd_en=1 -> busy=0, rd_vld=0, rd_data=0 throughout. Deassert -> idle, no spurious rd_vld.
- Word write/read, WAIT_STATES=2: write 0xDEADBEEF at 0x10, then read 0x10.
  - Required: busy high 3 cycles per access; rd_vld 4 cycles after the read request; rd_data=0xDEADBEEF.
- Byte/half lanes: word 0x0 at 0x20, byte write 0xA5 at 0x22, half write 0x1234 at 0x20.
  - Word read -> 0x00A51234; byte read at 0x22 -> 0x000000A5; half read at 0x22 -> 0x000000A5.
- Collision and ignore: rd_en and wr_en together (data 0x55, word, addr 0x4) -> write performed, no rd_vld. A request during busy -> no effect. Read 0x4 -> 0x00000055.
- Wrap: with ADDR_WIDTH=10, write 0x11 at 0x1000 -> a read at 0x0 returns 0x00000011.
- Reset mid-write: write 0xFFFFFFFF to a location holding 0x0, pulse rst_n low in the WAIT cycle -> a later read returns 0x00000000.
